sha256_host_mem: RTL and testbench

SHA256_HOST_MEM -- requirements
Module: sha256_host_mem

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_dp_ram.sv | 50 +++++
 rtl/sha256_host_mem.sv | 130 +++++++++++++
 tb/tb_sha256_host_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host/memory wrapper: controller states,
// default buffer base addresses and digest length.
package sha256_pkg;

  localparam logic [15:0] MSG_BASE_DEF = 16'h0000;
  localparam logic [15:0] OUT_BASE_DEF = 16'h0020;
  localparam int          DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    UNLOAD_REQ,
    UNLOAD_DATA
  } state_e;

endpackage

// File: rtl/sha256_dp_ram.sv
// Two-port word memory shared by the host controller (port A) and the hasher
// (port B). Synchronous writes, registered reads, out-of-range accesses inert.
module sha256_dp_ram #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_we_i,
  input  logic        a_re_i,
  input  logic [15:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic [31:0] a_rdata_o,
  input  logic        b_we_i,
  input  logic [15:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic [31:0] b_rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;
  logic        a_in_range;
  logic        b_in_range;

  assign a_in_range = ({16'b0, a_addr_i} < 32'(DEPTH));
  assign b_in_range = ({16'b0, b_addr_i} < 32'(DEPTH));

  // Host write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (b_we_i && b_in_range) mem[b_addr_i[AW-1:0]] <= b_wdata_i;
    if (a_we_i && a_in_range) mem[a_addr_i[AW-1:0]] <= a_wdata_i;
  end

  // Port A only updates on request so the unload word stays put while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) a_rdata_q <= a_in_range ? mem[a_addr_i[AW-1:0]] : '0;
      b_rdata_q <= b_in_range ? mem[b_addr_i[AW-1:0]] : '0;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sha256_host_mem.sv
// Host-side wrapper around a SHA-256 hasher: streams message words into the
// shared memory, kicks the hasher, waits for completion and streams the digest out.
module sha256_host_mem
  import sha256_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 20,
  parameter int          DEPTH        = 64,
  parameter logic [15:0] MSG_BASE     = MSG_BASE_DEF,
  parameter logic [15:0] OUT_BASE     = OUT_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        start,
  input  logic        done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam logic [4:0] LAST_MSG = 5'(NUM_OF_WORDS - 1);
  localparam logic [4:0] LAST_DIG = 5'(DIGEST_WORDS - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        host_we;
  logic        host_re;
  logic [15:0] host_addr;

  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;
  assign busy         = (state_q != LOAD);
  assign host_addr    = (state_q == LOAD) ? MSG_BASE + {11'b0, cnt_q}
                                          : OUT_BASE + {11'b0, cnt_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    host_we   = 1'b0;
    host_re   = 1'b0;
    start     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          host_we = 1'b1;
          if (cnt_q == LAST_MSG) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      START: begin
        start   = 1'b1;
        state_d = WAIT_LOW;
      end
      // done may still be high from the previous job; wait for it to drop first.
      WAIT_LOW: if (!done) state_d = WAIT_HIGH;
      WAIT_HIGH: begin
        if (done) begin
          cnt_d   = '0;
          state_d = UNLOAD_REQ;
        end
      end
      UNLOAD_REQ: begin
        host_re = 1'b1;
        state_d = UNLOAD_DATA;
      end
      UNLOAD_DATA: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == LAST_DIG);
        if (out_ready) begin
          if (cnt_q == LAST_DIG) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = UNLOAD_REQ;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
    endcase
  end

  sha256_dp_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_we_i    (host_we),
    .a_re_i    (host_re),
    .a_addr_i  (host_addr),
    .a_wdata_i (in_data),
    .a_rdata_o (out_data),
    .b_we_i    (mem_we),
    .b_addr_i  (mem_addr),
    .b_wdata_i (mem_write_data),
    .b_rdata_o (mem_read_data)
  );

endmodule

// File: tb/tb_sha256_host_mem.sv
// Directed bench for sha256_host_mem: load, hasher-port access table,
// done handshake, stalled digest unload, mid-job reset and write collision.
module tb_sha256_host_mem;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   vecCount   = 0;
  int   errCount   = 0;
  int   startCount = 0;
  bit   doneRaised = 0;
  bit   earlyValid = 0;

  sha256_host_mem dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .done           (done),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) startCount++;
    if (!doneRaised && out_valid === 1'b1) earlyValid = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                 input bit chk, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Drive one hasher-port access at a negedge; the registered read is visible one edge later.
  task automatic applyStimulus(input vec_t v);
    mem_we         = v.we;
    mem_addr       = v.addr;
    mem_write_data = v.wdata;
    @(negedge clk);
    mem_we = 1'b0;
    if (v.chk) checkOutput($sformatf("hread_%h", v.addr), mem_read_data, v.exp);
  endtask

  task automatic loadWords(input int n, input logic [31:0] base, input bit lastStarts);
    bit stayErr = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'hFFFF_FFFF;
      if (i < n - 1 || !lastStarts) begin
        if (busy !== 1'b0 || start !== 1'b0 || in_ready !== 1'b1) stayErr = 1;
        @(negedge clk);
      end
    end
    checkOutput("loadStaysInLoad", 32'(stayErr), 32'd0);
    if (lastStarts) begin
      checkOutput("startAfterLastWord", 32'(start), 32'd1);
      checkOutput("inReadyLowInStart", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("startOneCycle", 32'(start), 32'd0);
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
    end
  endtask

  task automatic unloadDigest();
    for (int w = 0; w < 8; w++) begin
      int t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      checkOutput($sformatf("digestWord%0d", w), out_data, 32'h1111_1111 * 32'(w + 1));
      checkOutput($sformatf("outLast%0d", w), 32'(out_last), (w == 7) ? 32'd1 : 32'd0);
      if (w == 2) begin
        logic [31:0] held = out_data;
        bit stallErr = 0;
        repeat (10) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== held || out_last !== 1'b0) stallErr = 1;
        end
        checkOutput("stallHoldsWord", 32'(stallErr), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (w < 7) checkOutput($sformatf("gapAfterWord%0d", w), 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    reset_n        = 1'b1;
    done           = 1'b1;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;

    for (int i = 0; i < 20; i++) addVec(1'b0, 16'(i), '0, 1'b1, 32'(i));
    addVec(1'b1, 16'h0005, 32'hDEAD_BEEF, 1'b1, 32'h0000_0005);
    addVec(1'b0, 16'h0005, '0, 1'b1, 32'hDEAD_BEEF);
    addVec(1'b0, 16'h0040, '0, 1'b1, 32'h0000_0000);
    addVec(1'b1, 16'h0040, 32'hCAFE_F00D, 1'b1, 32'h0000_0000);
    addVec(1'b0, 16'h0000, '0, 1'b1, 32'h0000_0000);
    for (int k = 0; k < 8; k++) addVec(1'b1, 16'h0020 + 16'(k), 32'h1111_1111 * 32'(k + 1), 1'b0, '0);
    addVec(1'b0, 16'h0027, '0, 1'b1, 32'h8888_8888);
    addVec(1'b0, 16'h0020, '0, 1'b1, 32'h1111_1111);

    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstStart", 32'(start), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutLast", 32'(out_last), 32'd0);
    checkOutput("rstOutData", out_data, 32'd0);
    checkOutput("rstMemReadData", mem_read_data, 32'd0);
    checkOutput("baseMsg", 32'(message_addr), 32'h0000);
    checkOutput("baseOut", 32'(output_addr), 32'h0020);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("inReadyAfterRelease", 32'(in_ready), 32'd1);

    loadWords(7, 32'h0000_00A0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midResetInReady", 32'(in_ready), 32'd1);
    checkOutput("midResetNoStart", 32'(startCount), 32'd0);

    loadWords(20, 32'h0000_0000, 1'b1);
    repeat (2) @(negedge clk);
    done = 1'b0;
    foreach (vecs[i]) applyStimulus(vecs[i]);
    for (int c = vecs.size(); c < 100; c++) @(negedge clk);
    checkOutput("busyWhileHashing", 32'(busy), 32'd1);
    doneRaised = 1'b1;
    done       = 1'b1;
    checkOutput("noEarlyUnload", 32'(earlyValid), 32'd0);
    unloadDigest();
    checkOutput("backToLoadBusy", 32'(busy), 32'd0);
    checkOutput("backToLoadInReady", 32'(in_ready), 32'd1);

    in_valid       = 1'b1;
    in_data        = 32'h1234_5678;
    mem_we         = 1'b1;
    mem_addr       = 16'h0000;
    mem_write_data = 32'hBADB_AD00;
    @(negedge clk);
    in_valid = 1'b0;
    mem_we   = 1'b0;
    @(negedge clk);
    checkOutput("hostWinsCollision", mem_read_data, 32'h1234_5678);
    checkOutput("singleStartPulse", 32'(startCount), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
